// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM encodings and multiply/divide selector for alu_seq.
// Single-cycle opcode values keep the existing ALU encoding; 12..15 are the iterative ops.
package alu_seq_pkg;

  localparam logic [5:0] ALU_OP_ADD   = 6'd0;
  localparam logic [5:0] ALU_OP_SUB   = 6'd1;
  localparam logic [5:0] ALU_OP_AND   = 6'd2;
  localparam logic [5:0] ALU_OP_OR    = 6'd3;
  localparam logic [5:0] ALU_OP_XOR   = 6'd4;
  localparam logic [5:0] ALU_OP_SLL   = 6'd5;
  localparam logic [5:0] ALU_OP_SRL   = 6'd6;
  localparam logic [5:0] ALU_OP_SRA   = 6'd7;
  localparam logic [5:0] ALU_OP_SLT   = 6'd8;
  localparam logic [5:0] ALU_OP_SLTU  = 6'd9;
  localparam logic [5:0] ALU_OP_MUL   = 6'd12;
  localparam logic [5:0] ALU_OP_MULHU = 6'd13;
  localparam logic [5:0] ALU_OP_DIVU  = 6'd14;
  localparam logic [5:0] ALU_OP_REMU  = 6'd15;

  localparam logic [1:0] ALU_ST_IDLE = 2'd0;
  localparam logic [1:0] ALU_ST_BUSY = 2'd1;
  localparam logic [1:0] ALU_ST_DONE = 2'd2;

  typedef enum logic [1:0] {MD_MUL, MD_MULHU, MD_DIVU, MD_REMU} md_op_t;

  function automatic logic is_iter(input logic [5:0] op);
    return (op == ALU_OP_MUL) || (op == ALU_OP_MULHU) ||
           (op == ALU_OP_DIVU) || (op == ALU_OP_REMU);
  endfunction

  function automatic md_op_t md_sel(input logic [5:0] op);
    case (op)
      ALU_OP_MULHU: return MD_MULHU;
      ALU_OP_DIVU:  return MD_DIVU;
      ALU_OP_REMU:  return MD_REMU;
      default:      return MD_MUL;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one step per cycle for WIDTH cycles.
// Loads on start; result is the value the final step writes, presented alongside done.
module alu_seq_muldiv
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  // acc high half: product high / remainder; low half: multiplier bits / quotient
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  md_op_t             op_q;
  logic [CW-1:0]      cnt;
  logic               busy;
  logic               is_div;
  logic               start_div;

  assign is_div    = (op_q == MD_DIVU) || (op_q == MD_REMU);
  assign start_div = (op == MD_DIVU) || (op == MD_REMU);
  assign done      = busy && (cnt == CW'(WIDTH - 1));

  always_comb begin
    sum     = '0;
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - opnd;
    acc_nxt = acc;
    if (is_div) begin
      // Divisor zero always "fits", giving all-ones quotient and remainder == A
      if (shifted >= {1'b0, opnd}) begin
        acc_nxt = {diff, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    case (op_q)
      MD_MUL, MD_DIVU: result = acc_nxt[WIDTH-1:0];
      default:         result = acc_nxt[2*WIDTH-1:WIDTH];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      opnd <= '0;
      op_q <= MD_MUL;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      acc  <= start_div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
      opnd <= start_div ? b : a;
      op_q <= op;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops latency 1, MUL/MULHU/DIVU/REMU latency WIDTH+1.
// owReady only in IDLE; result held in DONE until iwReady, so the issuer stalls meanwhile.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             iwClk,
  input  logic             iwRst,
  input  logic             iwValid,
  output logic             owReady,
  input  logic [WIDTH-1:0] iwA,
  input  logic [WIDTH-1:0] iwB,
  input  logic [5:0]       iwAluOp,
  output logic             owValid,
  input  logic             iwReady,
  output logic [WIDTH-1:0] owResult,
  output logic             owZero,
  output logic             owSign
);

  logic [1:0]       state;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] md_result;
  logic [SHW-1:0]   shamt;
  logic             accept;
  logic             md_start;
  logic             md_done;
  md_op_t           md_op;

  assign owReady  = (state == ALU_ST_IDLE);
  assign owValid  = (state == ALU_ST_DONE);
  assign accept   = iwValid && owReady;
  assign md_start = accept && is_iter(iwAluOp);
  assign md_op    = md_sel(iwAluOp);
  assign shamt    = iwB[SHW-1:0];
  assign owResult = res;
  assign owZero   = (res == '0);
  assign owSign   = res[WIDTH-1];

  always_comb begin
    alu_res = '0;
    case (iwAluOp)
      ALU_OP_ADD:  alu_res = iwA + iwB;
      ALU_OP_SUB:  alu_res = iwA - iwB;
      ALU_OP_AND:  alu_res = iwA & iwB;
      ALU_OP_OR:   alu_res = iwA | iwB;
      ALU_OP_XOR:  alu_res = iwA ^ iwB;
      ALU_OP_SLL:  alu_res = iwA << shamt;
      ALU_OP_SRL:  alu_res = iwA >> shamt;
      ALU_OP_SRA:  alu_res = $signed(iwA) >>> shamt;
      ALU_OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(iwA) < $signed(iwB))};
      ALU_OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (iwA < iwB)};
      default:     alu_res = '0;
    endcase
  end

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (iwClk),
    .rst    (iwRst),
    .start  (md_start),
    .op     (md_op),
    .a      (iwA),
    .b      (iwB),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      state <= ALU_ST_IDLE;
      res   <= '0;
    end else begin
      case (state)
        ALU_ST_IDLE: begin
          if (accept) begin
            if (is_iter(iwAluOp)) begin
              state <= ALU_ST_BUSY;
            end else begin
              res   <= alu_res;
              state <= ALU_ST_DONE;
            end
          end
        end
        ALU_ST_BUSY: begin
          if (md_done) begin
            res   <= md_result;
            state <= ALU_ST_DONE;
          end
        end
        ALU_ST_DONE: begin
          // No accept here even with iwReady high: IDLE must be re-entered first
          if (iwReady) state <= ALU_ST_IDLE;
        end
        default: state <= ALU_ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the combinational ALU.
- Executes the existing ALU op set in one registered cycle.
- Adds iterative unsigned multiply and divide: ALU_OP_MUL, ALU_OP_MULHU, ALU_OP_DIVU, ALU_OP_REMU.
- Sits between decode/issue and writeback. Stalls the issuer through a valid/ready handshake while a multi-cycle op runs.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, ≥ 8.
- SHW, $clog2(WIDTH), number of shift-amount bits taken from iwB.

Ports:
- iwClk  input  1  clock; all state updates on the rising edge.
- iwRst  input  1  synchronous, active-high reset.
- iwValid  input  1  request valid.
- owReady  output  1  block can accept a request; high only in IDLE.
- iwA  input  WIDTH  operand A.
- iwB  input  WIDTH  operand B.
- iwAluOp  input  6  operation code, encoded per macros/aluops.v.
- owValid  output  1  result valid; held until consumed.
- iwReady  input  1  consumer accepts the result.
- owResult  output  WIDTH  registered result.
- owZero  output  1  owResult == 0.
- owSign  output  1  owResult[WIDTH-1].

Behaviour:
- Reset: state=IDLE, owValid=0, owResult=0, owReady=1 in the cycle after reset deasserts. owZero=1 and owSign=0 follow from owResult.
- Reset mid-operation: the in-flight op is discarded, no owValid is produced, and the iterative datapath is cleared.
- States:
  - IDLE: owReady=1, owValid=0.
  - BUSY: owReady=0, owValid=0.
  - DONE: owReady=0, owValid=1.
- Accept: a request is accepted when iwValid && owReady in IDLE. iwA, iwB and iwAluOp are captured; later input changes have no effect.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, and any unknown op):
  - IDLE -> DONE on the accept edge; owValid rises the next cycle (latency 1).
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLL/SRL/SRA use iwB[SHW-1:0] only.
  - SRA is a true arithmetic shift: sign-fill from A[WIDTH-1].
  - SLT is a signed two's-complement compare; SLTU is unsigned. Both produce 0 or 1, zero-extended.
  - Unknown op produces 0.
- Iterative ops:
  - IDLE -> BUSY on accept. BUSY lasts exactly WIDTH cycles, then -> DONE.
  - owValid is asserted WIDTH+1 cycles after the accept edge.
  - MUL returns the low WIDTH bits of the unsigned A*B; MULHU returns the high WIDTH bits of the 2*WIDTH-bit product. Implemented as one shift-add step per cycle into a 2*WIDTH accumulator.
  - DIVU/REMU use restoring division, one quotient bit per cycle. DIVU returns the quotient, REMU the remainder.
  - Divide by zero: DIVU = all ones, REMU = A. Takes the full WIDTH cycles (no early exit), so latency stays fixed.
- Output hold: in DONE, owResult/owValid stay stable until iwReady=1. DONE -> IDLE on that edge; owValid drops the next cycle.
- No accept occurs in the DONE cycle, even if iwReady=1 in that same cycle. Maximum throughput is one single-cycle op every 2 cycles.
- owZero/owSign are combinational from the registered owResult; they are valid whenever owValid=1.
- iwValid while owReady=0 is ignored. The issuer must hold the request until it is accepted.

Decomposition:
- macros/aluops.v (shared include):
  - existing ALU_OP_* codes, unchanged;
  - new codes ALU_OP_MUL, ALU_OP_MULHU, ALU_OP_DIVU, ALU_OP_REMU;
  - state encodings ALU_ST_IDLE/BUSY/DONE.
- Sub-module alu_seq_muldiv, parametrised by WIDTH:
  - ports: start, op select (mul/mulhu/divu/remu), A, B, done, result;
  - owns the 2*WIDTH accumulator and the iteration counter.
- alu_seq top level owns the handshake FSM and the single-cycle datapath.

Test Plan (all cases WIDTH=32 unless stated):
- Reset mid-DIVU: reset asserted in BUSY cycle 10 -> next cycle owValid=0, owReady=1, owResult=0; a following ADD 2+3 -> 5 with latency 1.
- ADD overflow and SUB: A=0xFFFFFFFF, B=1 -> owResult=0, owZero=1, owValid 1 cycle after accept. SUB A=1, B=2 -> 0xFFFFFFFF, owSign=1.
- Shifts and compares:
  - SRA A=0x80000000, B=0x24 -> 0xF8000000 (shift amount 4 from B[4:0]).
  - SLT A=0xFFFFFFFF, B=1 -> 1.
  - SLTU with the same operands -> 0.
- Multiply: MUL A=0xFFFFFFFF, B=0xFFFFFFFF -> 0x00000001. MULHU with the same operands -> 0xFFFFFFFE. owValid asserted exactly 33 cycles after accept; owReady=0 throughout.
- Divide: DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU x/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
- Backpressure and width: hold iwReady=0 for 5 cycles in DONE -> owResult/owValid stable and iwValid ignored; release -> IDLE, next request accepted. Repeat MUL 0xFF*0xFF with WIDTH=8 -> low 0x01, MULHU 0xFE, latency 9.
